mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter MAX_DSTREAK, default 4, max consecutive data grants while an instruction request waits.
REQ-002 Parameter TIMEOUT, default 15, max cycles in a busy state awaiting MemAck.
REQ-003 The block SHALL use one clock; reset is asynchronous and active-low, with ports named clk and reset.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 reset  in  1  asynchronous active-low reset.
REQ-006 IReq  in  1  fetch-stage read request, held until IReady.
REQ-007 IAddr  in  32  fetch address, PCF.
REQ-008 IRData  out  32  instruction read data.
REQ-009 IReady  out  1  one-cycle completion pulse for fetch.
REQ-010 DReq  in  1  memory-stage request, held until DReady.
REQ-011 DWrite  in  1  1 = store, 0 = load.
REQ-012 DAddr  in  32  data address, ALUOutM.
REQ-013 DWData  in  32  store data, WriteDataM.
REQ-014 DRData  out  32  load data, ReadDataM.
REQ-015 DReady  out  1  one-cycle completion pulse for data.
REQ-016 MemReq  out  1  unified single-port memory request, high while busy.
REQ-017 MemWE  out  1  memory write enable.
REQ-018 MemAddr  out  32  memory address.
REQ-019 MemWData  out  32  memory write data.
REQ-020 MemRData  in  32  memory read data, valid with MemAck.
REQ-021 MemAck  in  1  memory completion, variable latency of at least 1 cycle.
REQ-022 StallMemF  out  1  IReq & ~IReady, fed to the hazard unit.
REQ-023 StallMemM  out  1  DReq & ~DReady, fed to the hazard unit.
REQ-024 BusErr  out  1  sticky timeout flag.

Function
REQ-025 The FSM SHALL have states IDLE, IBUSY and DBUSY; MemReq SHALL equal (state != IDLE).
REQ-026 In IDLE, a requester whose Ready is high in the current cycle SHALL be ignored for arbitration.
REQ-027 Arbitration in IDLE: data SHALL win over instruction, unless streak == MAX_DSTREAK and both request, in which case instruction SHALL win.
REQ-028 At the granting edge, MemAddr, MemWE and MemWData SHALL be registered from the winner; MemWE SHALL be 0 for instruction grants.
REQ-029 The streak counter SHALL increment on a data grant while IReq is high, and clear on an instruction grant or when IReq is low in IDLE.
REQ-030 In IBUSY/DBUSY with MemAck sampled high: return to IDLE, pulse the matching Ready in the next cycle, and capture MemRData into IRData (instruction) or DRData (load only).
REQ-031 DRData SHALL hold its value across stores; IRData and DRData SHALL hold until the next capture.
REQ-032 Latency: request in cycle 0, MemReq high from cycle 1, MemAck in cycle n, Ready in cycle n+1; the minimum is 3 cycles.
REQ-033 The timeout counter SHALL clear on grant and increment each busy cycle; on reaching TIMEOUT without MemAck: go to IDLE, pulse Ready, load read data with ERR_DATA (32'hDEADBEEF), and set BusErr.
REQ-034 If MemAck and timeout coincide, MemAck SHALL take precedence and BusErr SHALL not set.
REQ-035 MemAck sampled in IDLE SHALL be ignored.
REQ-036 IReady and DReady SHALL never be high in the same cycle.

Reset
REQ-037 While reset is low: state IDLE, and all outputs 0, including MemReq, Ready, RData, BusErr and the counters, asynchronously.
REQ-038 Reset during busy SHALL drop MemReq immediately, and the abandoned transfer SHALL produce no Ready after release.

Structure
REQ-039 The shared package arm_mem_pkg SHALL hold the state enum typedef, the ERR_DATA constant, and the MAX_DSTREAK/TIMEOUT defaults.
REQ-040 One sub-module, mem_timeout_counter (clear, enable, terminal-count output), SHALL implement the timeout counter.

Verification
REQ-041 Single load: DReq=1, DAddr=0x40, MemAck in cycle 2 with MemRData=0x1234 -> DReady pulses in cycle 3, DRData=0x1234, StallMemM high in cycles 0-2.
REQ-042 Contention: IReq and DReq held continuously for 10 grants -> grant pattern D,D,D,D,I repeating, never more than 4 consecutive D grants.
REQ-043 Store: DWrite=1, DAddr=0x80, DWData=0xA5A5A5A5 -> MemWE=1 and MemWData=0xA5A5A5A5 while busy, DRData unchanged.
REQ-044 Timeout: IReq=1, MemAck never -> IReady in cycle 17, IRData=0xDEADBEEF, BusErr=1 held until reset.
REQ-045 Reset mid-operation: reset low in cycle 2 of DBUSY -> MemReq=0 the same cycle, with no DReady after release.
REQ-046 Ack/timeout tie: MemAck on the TIMEOUT cycle -> normal data returned, BusErr stays 0.

Source files
------------

// File: rtl/arm_mem_pkg.sv
// Shared types and constants for the unified-memory arbiter between the fetch
// and memory stages.
package arm_mem_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        IBUSY = 2'd1,
        DBUSY = 2'd2
    } arb_state_t;

    localparam logic [31:0] ERR_DATA        = 32'hDEADBEEF;
    localparam int          MAX_DSTREAK_DEF = 4;
    localparam int          TIMEOUT_DEF     = 15;

    // Bits needed to hold values 0..maxval.
    function automatic int cnt_w(input int maxval);
        return (maxval < 1) ? 1 : $clog2(maxval + 1);
    endfunction

endpackage

// File: rtl/mem_timeout_counter.sv
// Busy-cycle counter for the arbiter. It is cleared on grant, counts while
// enabled, and flags the terminal count once it reaches TIMEOUT.
module mem_timeout_counter
    import arm_mem_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic tc
);

    localparam int W = cnt_w(TIMEOUT);

    logic [W-1:0] count;

    assign tc = (count == W'(TIMEOUT));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !tc) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates a single-port memory between instruction fetch and data access.
// Data normally wins, but fetch is guaranteed a slot after MAX_DSTREAK data grants.
module mem_arbiter
    import arm_mem_pkg::*;
#(
    parameter int MAX_DSTREAK = MAX_DSTREAK_DEF,
    parameter int TIMEOUT     = TIMEOUT_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        IReq,
    input  logic [31:0] IAddr,
    output logic [31:0] IRData,
    output logic        IReady,
    input  logic        DReq,
    input  logic        DWrite,
    input  logic [31:0] DAddr,
    input  logic [31:0] DWData,
    output logic [31:0] DRData,
    output logic        DReady,
    output logic        MemReq,
    output logic        MemWE,
    output logic [31:0] MemAddr,
    output logic [31:0] MemWData,
    input  logic [31:0] MemRData,
    input  logic        MemAck,
    output logic        StallMemF,
    output logic        StallMemM,
    output logic        BusErr
);

    localparam int SW = cnt_w(MAX_DSTREAK);

    arb_state_t    state, state_next;
    logic [SW-1:0] streak;
    logic          busy, arb_open, i_want, d_want, streak_full;
    logic          grant_i, grant_d, ack_done, tout_done, finish, tc;

    assign busy        = (state != IDLE);
    assign MemReq      = busy;
    assign StallMemF   = IReq & ~IReady;
    assign StallMemM   = DReq & ~DReady;
    assign streak_full = (streak == SW'(MAX_DSTREAK));
    assign finish      = ack_done | tout_done;

    // A requester that just completed presents its next request only in the
    // following cycle, so no grant is made while any Ready is high; both sides
    // then compete on equal terms one cycle later.
    assign arb_open = ~(IReady | DReady);
    assign i_want   = IReq & arb_open;
    assign d_want   = DReq & arb_open;

    mem_timeout_counter #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk    (clk),
        .reset  (reset),
        .clear  (grant_i | grant_d),
        .enable (busy),
        .tc     (tc)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        grant_i    = 1'b0;
        grant_d    = 1'b0;
        ack_done   = 1'b0;
        tout_done  = 1'b0;
        case (state)
            IDLE: begin
                if (d_want && !(i_want && streak_full)) begin
                    grant_d    = 1'b1;
                    state_next = DBUSY;
                end else if (i_want) begin
                    grant_i    = 1'b1;
                    state_next = IBUSY;
                end
            end
            IBUSY, DBUSY: begin
                // An acknowledge on the terminal-count cycle still counts as success.
                if (MemAck) begin
                    ack_done   = 1'b1;
                    state_next = IDLE;
                end else if (tc) begin
                    tout_done  = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            IReady   <= 1'b0;
            DReady   <= 1'b0;
            IRData   <= '0;
            DRData   <= '0;
            MemWE    <= 1'b0;
            MemAddr  <= '0;
            MemWData <= '0;
            BusErr   <= 1'b0;
            streak   <= '0;
        end else begin
            IReady <= finish && (state == IBUSY);
            DReady <= finish && (state == DBUSY);

            if (grant_i) begin
                MemAddr  <= IAddr;
                MemWE    <= 1'b0;
                MemWData <= '0;
            end else if (grant_d) begin
                MemAddr  <= DAddr;
                MemWE    <= DWrite;
                MemWData <= DWData;
            end else if (finish) begin
                MemWE <= 1'b0;
            end

            if (finish && (state == IBUSY)) begin
                IRData <= ack_done ? MemRData : ERR_DATA;
            end
            // Stores leave the load-data register untouched.
            if (finish && (state == DBUSY) && !MemWE) begin
                DRData <= ack_done ? MemRData : ERR_DATA;
            end

            if (tout_done) begin
                BusErr <= 1'b1;
            end

            if (grant_i) begin
                streak <= '0;
            end else if (grant_d && IReq) begin
                streak <= streak_full ? streak : streak + SW'(1);
            end else if ((state == IDLE) && !IReq) begin
                streak <= '0;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a memory responder with programmable ack
// latency inside tick(), and queues holding the expected grants and read data.
module tb_mem_arbiter;
    import arm_mem_pkg::*;

    localparam logic [31:0] RD_KEY = 32'hC0DE0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        IReq, DReq, DWrite, MemAck;
    logic [31:0] IAddr, DAddr, DWData, MemRData;
    logic [31:0] IRData, DRData, MemAddr, MemWData;
    logic        IReady, DReady, MemReq, MemWE, StallMemF, StallMemM, BusErr;

    int          checks = 0;
    int          errors = 0;
    int          ack_lat = 0;
    int          busy_cnt = 0;
    bit          fixed_mode = 1'b1;
    logic [31:0] fixed_rdata = '0;

    logic [31:0] iq[$];
    logic [31:0] dq[$];
    bit          grant_q[$];

    always #5 clk = ~clk;

    mem_arbiter dut (
        .clk       (clk),
        .reset     (reset),
        .IReq      (IReq),
        .IAddr     (IAddr),
        .IRData    (IRData),
        .IReady    (IReady),
        .DReq      (DReq),
        .DWrite    (DWrite),
        .DAddr     (DAddr),
        .DWData    (DWData),
        .DRData    (DRData),
        .DReady    (DReady),
        .MemReq    (MemReq),
        .MemWE     (MemWE),
        .MemAddr   (MemAddr),
        .MemWData  (MemWData),
        .MemRData  (MemRData),
        .MemAck    (MemAck),
        .StallMemF (StallMemF),
        .StallMemM (StallMemM),
        .BusErr    (BusErr)
    );

    // Advance to just after the next rising edge and update the memory model.
    task automatic tick();
        @(posedge clk);
        #1;
        busy_cnt = MemReq ? busy_cnt + 1 : 0;
        MemAck   = (ack_lat != 0) && MemReq && (busy_cnt == ack_lat);
        MemRData = fixed_mode ? fixed_rdata : (MemAddr ^ RD_KEY);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_pop(input string tag, input bit is_d, input logic [31:0] obs);
        logic [31:0] exp;
        checks++;
        assert ((is_d ? dq.size() : iq.size()) != 0)
        else begin
            errors++;
            $error("FAIL %s observed=unexpected-completion expected=queued-entry", tag);
        end
        if (is_d && dq.size() != 0) begin
            exp = dq.pop_front();
            chk(tag, obs, exp);
        end else if (!is_d && iq.size() != 0) begin
            exp = iq.pop_front();
            chk(tag, obs, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=no-finish expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          grants, dstreak, max_streak, cyc, ready_cyc, dr_seen;
        bit          prev_memreq, saw_i, saw_d, stop_new, is_d;
        logic [31:0] iaddr, daddr;

        reset = 1'b0;
        IReq = 1'b0; DReq = 1'b0; DWrite = 1'b0; MemAck = 1'b0;
        IAddr = '0; DAddr = '0; DWData = '0; MemRData = '0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_memreq", MemReq, 0);
        chk("rst_iready", IReady, 0);
        chk("rst_dready", DReady, 0);
        chk("rst_irdata", IRData, 0);
        chk("rst_drdata", DRData, 0);
        chk("rst_buserr", BusErr, 0);
        chk("rst_memwe", MemWE, 0);
        chk("rst_memaddr", MemAddr, 0);
        reset = 1'b1;

        // Single load, ack in cycle 2
        ack_lat = 2; fixed_mode = 1'b1; fixed_rdata = 32'h1234;
        tick();
        DReq = 1'b1; DWrite = 1'b0; DAddr = 32'h40;
        dq.push_back(32'h1234);
        @(negedge clk);
        chk("load_c0_stallm", StallMemM, 1);
        chk("load_c0_memreq", MemReq, 0);
        tick(); @(negedge clk);
        chk("load_c1_memreq", MemReq, 1);
        chk("load_c1_memaddr", MemAddr, 32'h40);
        chk("load_c1_memwe", MemWE, 0);
        chk("load_c1_stallm", StallMemM, 1);
        tick(); @(negedge clk);
        chk("load_c2_stallm", StallMemM, 1);
        chk("load_c2_dready", DReady, 0);
        tick(); @(negedge clk);
        chk("load_c3_dready", DReady, 1);
        chk("load_c3_iready", IReady, 0);
        chk_pop("load_c3_drdata", 1'b1, DRData);
        chk("load_c3_stallm", StallMemM, 0);
        chk("load_c3_memreq", MemReq, 0);
        tick();
        DReq = 1'b0;
        @(negedge clk);
        chk("load_c4_dready", DReady, 0);

        // Store: write data presented, load data preserved
        fixed_rdata = 32'hFFFF0000;
        tick();
        DReq = 1'b1; DWrite = 1'b1; DAddr = 32'h80; DWData = 32'hA5A5A5A5;
        dq.push_back(32'h1234);
        tick(); @(negedge clk);
        chk("store_c1_memwe", MemWE, 1);
        chk("store_c1_memwdata", MemWData, 32'hA5A5A5A5);
        chk("store_c1_memaddr", MemAddr, 32'h80);
        tick(); @(negedge clk);
        chk("store_c2_memwe", MemWE, 1);
        tick(); @(negedge clk);
        chk("store_c3_dready", DReady, 1);
        chk_pop("store_drdata_kept", 1'b1, DRData);
        tick();
        DReq = 1'b0; DWrite = 1'b0;

        // Contention: both requesters always present
        fixed_mode = 1'b0; ack_lat = 2;
        for (int k = 0; k < 10; k++) grant_q.push_back((k % 5) != 4);
        iaddr = 32'h1000; daddr = 32'h2000;
        grants = 0; dstreak = 0; max_streak = 0; cyc = 0;
        prev_memreq = 1'b0; saw_i = 1'b0; saw_d = 1'b0; stop_new = 1'b0;
        tick();
        IReq = 1'b1; IAddr = iaddr; iq.push_back(iaddr ^ RD_KEY);
        DReq = 1'b1; DAddr = daddr; dq.push_back(daddr ^ RD_KEY);
        while ((IReq || DReq) && cyc < 300) begin
            if (cyc != 0) tick();
            cyc++;
            if (saw_d) begin
                if (stop_new) DReq = 1'b0;
                else begin
                    daddr += 4; DAddr = daddr; dq.push_back(daddr ^ RD_KEY);
                end
                saw_d = 1'b0;
            end
            if (saw_i) begin
                if (stop_new) IReq = 1'b0;
                else begin
                    iaddr += 4; IAddr = iaddr; iq.push_back(iaddr ^ RD_KEY);
                end
                saw_i = 1'b0;
            end
            @(negedge clk);
            if (MemReq && !prev_memreq) begin
                is_d = (MemAddr[13:12] == 2'd2);
                if (grant_q.size() != 0)
                    chk($sformatf("grant%0d_is_data", grants), is_d, grant_q.pop_front());
                grants++;
                dstreak    = is_d ? dstreak + 1 : 0;
                max_streak = (dstreak > max_streak) ? dstreak : max_streak;
                if (grants >= 10) stop_new = 1'b1;
            end
            prev_memreq = MemReq;
            if (IReady || DReady) chk("ready_exclusive", IReady & DReady, 0);
            if (IReady) begin chk_pop("cont_irdata", 1'b0, IRData); saw_i = 1'b1; end
            if (DReady) begin chk_pop("cont_drdata", 1'b1, DRData); saw_d = 1'b1; end
        end
        chk("cont_terminated", (cyc < 300), 1);
        chk("cont_max_dstreak", max_streak, 4);
        chk("cont_grants_ge10", (grants >= 10), 1);
        chk("cont_queues_drained", iq.size() + dq.size(), 0);

        // Timeout on a fetch, memory never acknowledges
        ack_lat = 0; fixed_mode = 1'b1; ready_cyc = -1;
        tick();
        IReq = 1'b1; IAddr = 32'h300;
        iq.push_back(ERR_DATA);
        for (int c = 1; c <= 40; c++) begin
            tick(); @(negedge clk);
            if (IReady) begin ready_cyc = c; break; end
        end
        chk("tout_ready_cycle", ready_cyc, 17);
        chk_pop("tout_irdata", 1'b0, IRData);
        chk("tout_buserr", BusErr, 1);
        tick();
        IReq = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        chk("tout_buserr_sticky", BusErr, 1);
        chk("tout_memreq_idle", MemReq, 0);
        reset = 1'b0;
        #1;
        chk("tout_buserr_cleared", BusErr, 0);
        chk("tout_irdata_cleared", IRData, 0);
        @(negedge clk);
        reset = 1'b1;

        // Ack arriving on the terminal-count cycle
        ack_lat = 16; fixed_rdata = 32'h600DDA7A; ready_cyc = -1;
        tick();
        DReq = 1'b1; DWrite = 1'b0; DAddr = 32'h44;
        dq.push_back(32'h600DDA7A);
        for (int c = 1; c <= 40; c++) begin
            tick(); @(negedge clk);
            if (DReady) begin ready_cyc = c; break; end
        end
        chk("tie_ready_cycle", ready_cyc, 17);
        chk_pop("tie_drdata", 1'b1, DRData);
        chk("tie_buserr", BusErr, 0);
        tick();
        DReq = 1'b0;

        // Reset asserted in the second busy cycle of a load
        ack_lat = 0;
        tick();
        DReq = 1'b1; DAddr = 32'h50;
        tick();
        tick();
        #2;
        reset = 1'b0; DReq = 1'b0;
        #1;
        chk("midrst_memreq", MemReq, 0);
        chk("midrst_dready", DReady, 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        dr_seen = 0;
        for (int c = 0; c < 20; c++) begin
            tick(); @(negedge clk);
            if (DReady) dr_seen++;
        end
        chk("midrst_no_dready", dr_seen, 0);
        chk("midrst_memreq_after", MemReq, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
